// File: rtl/display_scheduler_pkg.sv
// Shared definitions for the display scheduler: FSM state encoding, defaults
// and the op-code labels that requesters put on the display.
package def;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    SWITCH = 2'd2
  } sched_state_t;

  localparam int DISPLAY_DWELL_MS_DEFAULT = 1000;
  localparam int DISPLAY_NUM_SOURCES_MAX  = 4;

  localparam logic [7:0] LDI = 8'h01;
  localparam logic [7:0] ADD = 8'h02;

  function automatic logic [DISPLAY_NUM_SOURCES_MAX-1:0] page_onehot(input logic [1:0] p);
    page_onehot    = '0;
    page_onehot[p] = 1'b1;
  endfunction

endpackage

// File: rtl/display_scheduler_rr_select.sv
// Combinational round-robin picker: first requester after 'page' (wrapping),
// the current owner itself excluded; only_self flags the owner as sole requester.
module rr_select #(
  parameter int NUM_SOURCES = 4
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [1:0]             page,
  output logic [1:0]             next_page,
  output logic                   found,
  output logic                   only_self
);

  logic [1:0] w_idx;

  // Scan farthest-first so the nearest candidate after 'page' wins.
  always_comb begin
    next_page = page;
    found     = 1'b0;
    w_idx     = '0;
    for (int k = NUM_SOURCES - 1; k >= 1; k--) begin
      w_idx = 2'((int'(page) + k) % NUM_SOURCES);
      if (req[w_idx]) begin
        next_page = w_idx;
        found     = 1'b1;
      end
    end
    only_self = ~found & req[page];
  end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin owner of the shared 7-segment display with fixed dwell time.
// Optional step push button advance when DISPLAY_SCHED_STEP_EN is defined.
module display_scheduler
  import def::*;
#(
  parameter int CLOCK_FREQ_HZ = 50_000_000,
  parameter int DWELL_MS      = DISPLAY_DWELL_MS_DEFAULT,
  parameter int NUM_SOURCES   = 4
) (
  input  logic                     clock,
  input  logic                     reset_s2_n,
  input  logic                     auto_en,
  input  logic                     step_n,
  input  logic [NUM_SOURCES-1:0]   req,
  input  logic [NUM_SOURCES*8-1:0] label,
  input  logic [NUM_SOURCES*8-1:0] value,
  output logic [NUM_SOURCES-1:0]   grant,
  output logic [1:0]               page,
  output logic                     enable,
  output logic [7:0]               op_code,
  output logic [7:0]               r16,
  output sched_state_t             state_dbg
);

  localparam int DWELL_CYCLES = CLOCK_FREQ_HZ / 1000 * DWELL_MS;
  localparam int CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  sched_state_t r_state, w_state_nxt;
  logic [1:0]       r_page, w_page_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_op, r_r16;

  logic       w_step_ev, w_expire, w_advance;
  logic [1:0] w_rr_page;
  logic       w_found, w_only_self;
  logic [7:0] w_lab, w_val;
  logic [DISPLAY_NUM_SOURCES_MAX-1:0] w_onehot;

`ifdef DISPLAY_SCHED_STEP_EN
  logic r_step_q;

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) r_step_q <= 1'b1;
    else             r_step_q <= step_n;
  end

  assign w_step_ev = r_step_q & ~step_n;
`else
  logic w_unused_step;
  assign w_unused_step = step_n;
  assign w_step_ev     = 1'b0;
`endif

  rr_select #(.NUM_SOURCES(NUM_SOURCES)) u_rr (
    .req       (req),
    .page      (r_page),
    .next_page (w_rr_page),
    .found     (w_found),
    .only_self (w_only_self)
  );

  assign w_expire  = auto_en && (r_cnt == CNT_W'(DWELL_CYCLES - 1));
  // A coincident expiry, step and owner drop collapse into one advance.
  assign w_advance = w_expire | w_step_ev | ~req[r_page];

  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt = SHOW;
          w_page_nxt  = w_found ? w_rr_page : r_page;
          w_cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (auto_en) w_cnt_nxt = r_cnt + 1'b1;
        if (w_advance) begin
          w_cnt_nxt = '0;
          if (w_found) begin
            w_state_nxt = SWITCH;
            w_page_nxt  = w_rr_page;
          end else if (!w_only_self) begin
            w_state_nxt = SWITCH;
          end
        end
      end
      SWITCH: begin
        w_cnt_nxt   = '0;
        w_state_nxt = (|req) ? SHOW : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_lab = '0;
    w_val = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (r_page == 2'(i)) begin
        w_lab = label[i*8 +: 8];
        w_val = value[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      r_state <= IDLE;
      r_page  <= 2'(NUM_SOURCES - 1);
      r_cnt   <= '0;
      r_op    <= '0;
      r_r16   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_page  <= w_page_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= (r_state == SHOW) ? w_lab : 8'h00;
      r_r16   <= (r_state == SHOW) ? w_val : 8'h00;
    end
  end

  assign w_onehot  = page_onehot(r_page);
  assign grant     = (r_state == SHOW) ? w_onehot[NUM_SOURCES-1:0] : '0;
  assign enable    = (r_state == SHOW);
  assign page      = r_page;
  assign op_code   = r_op;
  assign r16       = r_r16;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a 10-cycle dwell configuration.
module tb_display_scheduler;
  import def::*;

  logic        clock = 1'b0;
  logic        reset_s2_n = 1'b0;
  logic        auto_en = 1'b0;
  logic        step_n = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] label = '0;
  logic [31:0] value = '0;
  logic [3:0]  grant;
  logic [1:0]  page;
  logic        enable;
  logic [7:0]  op_code;
  logic [7:0]  r16;
  sched_state_t state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  display_scheduler #(
    .CLOCK_FREQ_HZ (10_000),
    .DWELL_MS      (1),
    .NUM_SOURCES   (4)
  ) dut (
    .clock      (clock),
    .reset_s2_n (reset_s2_n),
    .auto_en    (auto_en),
    .step_n     (step_n),
    .req        (req),
    .label      (label),
    .value      (value),
    .grant      (grant),
    .page       (page),
    .enable     (enable),
    .op_code    (op_code),
    .r16        (r16),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    reset_s2_n = 1'b0;
    req        = '0;
    auto_en    = 1'b0;
    step_n     = 1'b1;
    label      = '0;
    value      = '0;
    repeat (2) @(negedge clock);
    reset_s2_n = 1'b1;
  endtask

  task automatic expect_grant(input string name, input logic [3:0] g, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      check(name, 32'(grant), 32'(g));
      check({name, "_en"}, 32'(enable), 32'(g != 4'b0000));
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] label;
    logic [31:0] value;
    logic [3:0]  e_grant;
    logic [1:0]  e_page;
    logic        e_en;
    logic [7:0]  e_op;
    logic [7:0]  e_r16;
  } vec_t;

  vec_t vecs[9];
  int own_seq[4];

  initial begin
    vecs[0] = '{4'b0001, 32'h0000_0001, 32'h0000_0002, 4'b0001, 2'd0, 1'b1, 8'h00, 8'h00};
    vecs[1] = '{4'b0001, 32'h0000_0001, 32'h0000_0002, 4'b0001, 2'd0, 1'b1, 8'h01, 8'h02};
    vecs[2] = '{4'b0001, 32'h0000_0001, 32'h0000_005A, 4'b0001, 2'd0, 1'b1, 8'h01, 8'h5A};
    vecs[3] = '{4'b0001, 32'h0000_0002, 32'h0000_005A, 4'b0001, 2'd0, 1'b1, 8'h02, 8'h5A};
    vecs[4] = '{4'b0000, 32'h0000_0002, 32'h0000_005A, 4'b0000, 2'd0, 1'b0, 8'h02, 8'h5A};
    vecs[5] = '{4'b0000, 32'h0000_0002, 32'h0000_005A, 4'b0000, 2'd0, 1'b0, 8'h00, 8'h00};
    vecs[6] = '{4'b0000, 32'h0000_0002, 32'h0000_005A, 4'b0000, 2'd0, 1'b0, 8'h00, 8'h00};
    vecs[7] = '{4'b0100, 32'h0033_0002, 32'h0044_005A, 4'b0100, 2'd2, 1'b1, 8'h00, 8'h00};
    vecs[8] = '{4'b0100, 32'h0033_0002, 32'h0044_005A, 4'b0100, 2'd2, 1'b1, 8'h33, 8'h44};
    own_seq = '{0, 1, 3, 0};

    // Reset values
    @(negedge clock);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_enable", 32'(enable), 32'h0);
    check("rst_op", 32'(op_code), 32'h0);
    check("rst_r16", 32'(r16), 32'h0);
    check("rst_page", 32'(page), 32'h3);
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // Reset release, data latency, owner drop and idle resume
    do_reset();
    check("ldi_const", 32'(LDI), 32'(vecs[1].e_op));
    check("add_const", 32'(ADD), 32'(vecs[3].e_op));
    for (int i = 0; i < 9; i++) begin
      req   = vecs[i].req;
      label = vecs[i].label;
      value = vecs[i].value;
      @(negedge clock);
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
      check($sformatf("vec%0d_page", i), 32'(page), 32'(vecs[i].e_page));
      check($sformatf("vec%0d_enable", i), 32'(enable), 32'(vecs[i].e_en));
      check($sformatf("vec%0d_op", i), 32'(op_code), 32'(vecs[i].e_op));
      check($sformatf("vec%0d_r16", i), 32'(r16), 32'(vecs[i].e_r16));
    end

    // Dwell rotation 0 -> 1 -> 3 -> 0, 10 SHOW cycles and one blank each
    do_reset();
    req     = 4'b1011;
    auto_en = 1'b1;
    for (int o = 0; o < 4; o++) begin
      expect_grant($sformatf("rot%0d", o), 4'(1 << own_seq[o]), 10);
      if (o < 3) expect_grant($sformatf("rot_gap%0d", o), 4'b0000, 1);
    end

    // Sole requester keeps the display across dwell expiry
    do_reset();
    req     = 4'b0010;
    auto_en = 1'b1;
    expect_grant("solo", 4'b0010, 25);

    // Owner 1 drops its request mid-dwell
    do_reset();
    req     = 4'b0010;
    auto_en = 1'b1;
    expect_grant("drop_own1", 4'b0010, 1);
    req = 4'b0111;
    expect_grant("drop_hold", 4'b0010, 3);
    req = 4'b0101;
    expect_grant("drop_gap", 4'b0000, 1);
    expect_grant("drop_own2", 4'b0100, 10);
    expect_grant("drop_gap2", 4'b0000, 1);
    expect_grant("drop_own0", 4'b0001, 1);

    // Step push button with auto advance off
    do_reset();
    req     = 4'b0011;
    auto_en = 1'b0;
    expect_grant("step_pre", 4'b0001, 1);
    step_n = 1'b0;
`ifdef DISPLAY_SCHED_STEP_EN
    expect_grant("step_gap", 4'b0000, 1);
    expect_grant("step_hold", 4'b0010, 6);
`else
    expect_grant("step_ignored", 4'b0001, 7);
`endif
    step_n = 1'b1;

    // Asynchronous reset during SWITCH
    do_reset();
    req     = 4'b1111;
    auto_en = 1'b1;
    label   = 32'hAABB_CCDD;
    value   = 32'h1122_3344;
    expect_grant("pre_sw", 4'b0001, 10);
    expect_grant("in_sw", 4'b0000, 1);
    check("sw_op_before_rst", 32'(op_code), 32'hDD);
    #1 reset_s2_n = 1'b0;
    #1;
    check("arst_sw_op", 32'(op_code), 32'h0);
    check("arst_sw_r16", 32'(r16), 32'h0);
    check("arst_sw_page", 32'(page), 32'h3);
    check("arst_sw_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clock);
    reset_s2_n = 1'b1;
    expect_grant("post_sw_rst", 4'b0001, 3);

    // Asynchronous reset mid-SHOW
    check("mid_op", 32'(op_code), 32'hDD);
    #1 reset_s2_n = 1'b0;
    #1;
    check("arst_show_grant", 32'(grant), 32'h0);
    check("arst_show_enable", 32'(enable), 32'h0);
    check("arst_show_op", 32'(op_code), 32'h0);
    check("arst_show_r16", 32'(r16), 32'h0);
    check("arst_show_page", 32'(page), 32'h3);
    @(negedge clock);
    reset_s2_n = 1'b1;
    expect_grant("post_show_rst", 4'b0001, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
